// File: rtl/event_scheduler_n.sv
// ---------------------------------------------------------------------------
// event_scheduler_n
//
// Turns edges on NUM_EV synchronised event lines into fixed-length tasks.
// The scheduler runs one task at a time. Each task stays active for TASK_LEN
// cycles. Requests that arrive while a task runs wait in a per-channel pending
// bit. An edge that arrives while its channel is already pending is lost and
// sets that channel's sticky overflow flag.
//
// Parameters
//   NUM_EV   : number of event channels (2..16)
//   TASK_LEN : cycles each granted task stays active (1..255)
//   RR_MODE  : 0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports
//   clk         : clock; all state updates on the rising edge
//   rst         : synchronous active-high reset
//   event_in    : event levels, already synchronised to clk
//   edge_mode   : per-channel mode in bits [2i+1:2i]
//                 00 rising, 01 falling, 10 both edges, 11 disabled
//   ovf_clr     : clears all overflow flags; a new overflow in the same cycle wins
//   task_active : one-hot or zero; bit i is high while channel i's task runs
//   pending     : queued requests that have not been granted yet
//   busy        : high while a task is active
//   overflow    : sticky per-channel flag; an edge was lost because the
//                 channel was already pending
// ---------------------------------------------------------------------------
module event_scheduler_n #(
    parameter int NUM_EV   = 4,
    parameter int TASK_LEN = 3,
    parameter int RR_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EV-1:0]     event_in,
    input  logic [2*NUM_EV-1:0]   edge_mode,
    input  logic                  ovf_clr,
    output logic [NUM_EV-1:0]     task_active,
    output logic [NUM_EV-1:0]     pending,
    output logic                  busy,
    output logic [NUM_EV-1:0]     overflow
);

    localparam int IW = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [7:0]        count;
    logic [IW-1:0]     rr_ptr;     // first index the round-robin search tries
    logic [NUM_EV-1:0] prev;

    logic [NUM_EV-1:0] det;
    logic [NUM_EV-1:0] grant_vec;
    logic [IW-1:0]     sel_idx;
    logic              sel_valid;
    logic              grant_en;
    logic [IW-1:0]     rr_next;
    int                cand;

    // Detect edges on each channel. The edge mode qualifies the change seen
    // between the registered copy and the current level.
    always_comb begin
        // NOTE: every variable written here gets a default value first. This
        // keeps the block purely combinational, so no latch is inferred.
        det = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            if (event_in[i] != prev[i]) begin
                unique case (edge_mode[2*i +: 2])
                    2'b00:   det[i] = event_in[i];
                    2'b01:   det[i] = ~event_in[i];
                    2'b10:   det[i] = 1'b1;
                    default: det[i] = 1'b0;
                endcase
            end
        end
    end

    // Select the next channel. Fixed priority scans upward from 0.
    // Round-robin scans upward from rr_ptr and wraps around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int j = 0; j < NUM_EV; j++) begin
            if (RR_MODE != 0)
                cand = (int'(rr_ptr) + j) % NUM_EV;
            else
                cand = j;
            if (!sel_valid && pending[IW'(cand)]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // A grant happens from IDLE, or at the last cycle of a running task.
    // Granting at the last cycle leaves no idle gap between back-to-back tasks.
    assign grant_en = sel_valid && ((state == IDLE) || (count == 8'd0));
    assign rr_next  = (sel_idx == IW'(NUM_EV - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        grant_vec = '0;
        if (grant_en)
            grant_vec[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: prev is loaded from event_in during reset, not cleared.
            // Lines that are already high at reset release then cause no edge.
            prev        <= event_in;
            state       <= IDLE;
            count       <= 8'd0;
            rr_ptr      <= '0;
            pending     <= '0;
            overflow    <= '0;
            task_active <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // right-hand side below therefore reads the pre-edge values.
            prev <= event_in;

            // The grant clears its old request. A new edge in the same cycle
            // queues the request again, and this is not an overflow.
            pending  <= (pending & ~grant_vec) | det;
            overflow <= (ovf_clr ? '0 : overflow) | (det & pending & ~grant_vec);

            if (grant_en) begin
                task_active <= grant_vec;
                count       <= 8'(TASK_LEN - 1);
                state       <= RUN;
                rr_ptr      <= rr_next;
            end else if (state == RUN) begin
                if (count == 8'd0) begin
                    task_active <= '0;
                    state       <= IDLE;
                end else begin
                    count <= count - 8'd1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_event_scheduler_n.sv
// ---------------------------------------------------------------------------
// tb_event_scheduler_n
//
// Drives one fixed-priority instance and one round-robin instance with the
// same stimulus. Each instance is compared every cycle against a
// task-level reference model. The model tracks the running channel, the
// cycles that channel has left, and the queued requests. Directed steps
// cover the documented scenarios. A randomised phase follows them.
// ---------------------------------------------------------------------------
module tb_event_scheduler_n;

    localparam int N  = 4;
    localparam int TL = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   event_in;
    logic [2*N-1:0] edge_mode;
    logic           ovf_clr;

    logic [N-1:0] ta_fp, pend_fp, ovf_fp;
    logic         busy_fp;
    logic [N-1:0] ta_rr, pend_rr, ovf_rr;
    logic         busy_rr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state. Index 0 is fixed priority, index 1 is round-robin.
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend [2];
    logic [N-1:0] m_ovf  [2];
    int           m_cur  [2];   // running channel, -1 when idle
    int           m_left [2];   // active cycles still to show, including the current one
    int           m_start[2];   // round-robin search start

    always #5 clk = ~clk;

    event_scheduler_n #(.NUM_EV(N), .TASK_LEN(TL), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .event_in(event_in), .edge_mode(edge_mode),
        .ovf_clr(ovf_clr), .task_active(ta_fp), .pending(pend_fp),
        .busy(busy_fp), .overflow(ovf_fp)
    );

    event_scheduler_n #(.NUM_EV(N), .TASK_LEN(TL), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .event_in(event_in), .edge_mode(edge_mode),
        .ovf_clr(ovf_clr), .task_active(ta_rr), .pending(pend_rr),
        .busy(busy_rr), .overflow(ovf_rr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int rr, input int start);
        int c;
        for (int j = 0; j < N; j++) begin
            c = (rr != 0) ? (start + j) % N : j;
            if (p[c]) return c;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the current inputs. Then
    // apply the edge to the DUTs and compare both instances after it.
    task automatic tick();
        logic [N-1:0] det;
        logic [N-1:0] gvec;
        logic [N-1:0] exp_ta;
        logic [1:0]   md;
        int ch;
        det = '0;
        for (int i = 0; i < N; i++) begin
            md = edge_mode[2*i +: 2];
            if (event_in[i] != m_prev[i]) begin
                case (md)
                    2'b00:   det[i] = event_in[i];
                    2'b01:   det[i] = !event_in[i];
                    2'b10:   det[i] = 1'b1;
                    default: det[i] = 1'b0;
                endcase
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_pend[m] = '0; m_ovf[m] = '0; m_cur[m] = -1; m_left[m] = 0; m_start[m] = 0;
            end else begin
                ch = -1;
                if (m_cur[m] < 0 || m_left[m] == 1) begin
                    ch = pick(m_pend[m], m, m_start[m]);
                    if (ch >= 0) begin
                        m_cur[m] = ch; m_left[m] = TL; m_start[m] = (ch + 1) % N;
                    end else begin
                        m_cur[m] = -1;
                    end
                end else begin
                    m_left[m]--;
                end
                gvec = '0;
                if (ch >= 0) gvec[ch] = 1'b1;
                m_ovf[m]  = (ovf_clr ? '0 : m_ovf[m]) | (det & m_pend[m] & ~gvec);
                m_pend[m] = (m_pend[m] & ~gvec) | det;
            end
        end
        m_prev = event_in;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_ta = '0;
            if (m_cur[m] >= 0) exp_ta[m_cur[m]] = 1'b1;
            if (m == 0) begin
                check("fp_task_active", 32'(ta_fp), 32'(exp_ta));
                check("fp_pending", 32'(pend_fp), 32'(m_pend[0]));
                check("fp_busy", 32'(busy_fp), 32'(m_cur[0] >= 0));
                check("fp_overflow", 32'(ovf_fp), 32'(m_ovf[0]));
            end else begin
                check("rr_task_active", 32'(ta_rr), 32'(exp_ta));
                check("rr_pending", 32'(pend_rr), 32'(m_pend[1]));
                check("rr_busy", 32'(busy_rr), 32'(m_cur[1] >= 0));
                check("rr_overflow", 32'(ovf_rr), 32'(m_ovf[1]));
            end
        end
    endtask

    initial begin
        int cnt, cnt_fp, cnt_rr;
        rst = 1'b1; event_in = '0; edge_mode = '0; ovf_clr = 1'b0;
        m_prev = '0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_ovf[m] = '0; m_cur[m] = -1; m_left[m] = 0; m_start[m] = 0;
        end
        tick(); tick();
        check("reset_busy", 32'(busy_fp), 32'd0);
        check("reset_task", 32'(ta_fp), 32'd0);
        rst = 1'b0;
        tick();

        // A single rising edge on channel 0 produces one task of TL cycles.
        event_in[0] = 1'b1; tick();
        check("single_pending", 32'(pend_fp), 32'h1);
        for (int t = 0; t < TL; t++) begin
            tick(); check("single_active", 32'(ta_fp), 32'h1);
        end
        tick(); check("single_idle", 32'(busy_fp), 32'd0);
        event_in = '0; tick();

        // Channels 1 and 2 rise together. The tasks run back to back.
        event_in = 4'b0110; tick();
        check("pair_pending", 32'(pend_fp), 32'h6);
        for (int t = 0; t < 2*TL; t++) begin
            tick();
            check("pair_seq", 32'(ta_fp), (t < TL) ? 32'h2 : 32'h4);
            check("pair_busy", 32'(busy_fp), 32'd1);
        end
        tick(); check("pair_done", 32'(busy_fp), 32'd0);
        event_in = '0; tick();

        // Channel 3 is set to falling-edge mode, then disabled.
        edge_mode = 8'b01_00_00_00;
        event_in[3] = 1'b1; tick(); check("fall_rise_ignored", 32'(pend_fp[3]), 32'd0);
        event_in[3] = 1'b0; tick(); check("fall_detected", 32'(pend_fp[3]), 32'd1);
        tick(); check("fall_task", 32'(ta_fp), 32'h8);
        repeat (4) tick();
        edge_mode[7:6] = 2'b11;
        event_in[3] = 1'b1; tick(); check("disabled_rise", 32'(pend_fp), 32'd0);
        event_in[3] = 1'b0; tick(); check("disabled_fall", 32'(pend_fp), 32'd0);
        check("disabled_idle", 32'(busy_fp), 32'd0);
        edge_mode = '0;

        // Channel 2 sees a second edge while channel 0 runs. Only one
        // channel-2 task runs, and the overflow flag is set.
        event_in = 4'b0101; tick();
        event_in[2] = 1'b0; tick(); check("ovf_ch0_runs", 32'(ta_fp), 32'h1);
        event_in[2] = 1'b1; tick();
        check("ovf_set", 32'(ovf_fp), 32'h4);
        check("ovf_pend_kept", 32'(pend_fp), 32'h4);
        cnt = 0;
        repeat (10) begin tick(); if (ta_fp[2]) cnt++; end
        check("ovf_one_task", 32'(cnt), 32'd3);
        ovf_clr = 1'b1; tick(); check("ovf_cleared", 32'(ovf_fp), 32'd0);
        ovf_clr = 1'b0; event_in = '0; tick();

        // Channels 0 and 1 are re-triggered every cycle. Round-robin
        // alternates between them, while fixed priority starves channel 1.
        edge_mode = 8'b00_00_10_10;
        cnt_fp = 0; cnt_rr = 0;
        for (int t = 0; t < 24; t++) begin
            event_in[1:0] = ~event_in[1:0];
            tick();
            if (ta_fp[1]) cnt_fp++;
            if (ta_rr[1]) cnt_rr++;
        end
        check("starve_fp_ch1", 32'(cnt_fp), 32'd0);
        check("rr_ch1_cycles", 32'(cnt_rr), 32'd11);
        event_in = '0; edge_mode = '0;
        repeat (12) tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Reset mid-task. Lines that stay high through reset cause no task.
        event_in = 4'b0010; tick();
        event_in[2] = 1'b1; tick(); check("rst_pre_task", 32'(ta_fp), 32'h2);
        tick();
        rst = 1'b1; event_in[0] = 1'b1; tick();
        check("rst_task", 32'(ta_fp), 32'd0);
        check("rst_pending", 32'(pend_fp), 32'd0);
        check("rst_busy_mid", 32'(busy_fp), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            check("post_rst_busy", 32'(busy_fp), 32'd0);
            check("post_rst_pending", 32'(pend_fp), 32'd0);
        end

        // Randomised phase, compared against the model every cycle.
        repeat (600) begin
            event_in = event_in ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/event_scheduler_n.md
EVENT_SCHEDULER_N -- requirements
Module: event_scheduler_n

Interface
REQ-001 Parameter NUM_EV, default 4: number of event channels, legal range 2..16.
REQ-002 Parameter TASK_LEN, default 3: cycles each granted task stays active, legal range 1..255.
REQ-003 Parameter RR_MODE, default 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 event_in  input  NUM_EV  asynchronous-free event levels; the source is already synchronised to clk.
REQ-007 edge_mode  input  2*NUM_EV  per-channel detect mode in bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 channel disabled.
REQ-008 ovf_clr  input  1  clears the overflow flags.
REQ-009 task_active  output  NUM_EV  one-hot or zero; bit i high while the task for channel i runs.
REQ-010 pending  output  NUM_EV  queued, not-yet-granted events, one bit per channel.
REQ-011 busy  output  1  high while any task is active.
REQ-012 overflow  output  NUM_EV  sticky per-channel flag: an event was lost because it was already pending.

Function
REQ-013 Each channel shall keep a registered copy prev[i] of event_in[i], updated every cycle.
REQ-014 Edge detect: det[i] = (event_in[i] != prev[i]), qualified by edge_mode: rising requires event_in=1, falling requires event_in=0, both accepts either, disabled never detects.
REQ-015 A detected edge at a clock edge shall set pending[i] at that same clock edge (visible the following cycle).
REQ-016 The FSM shall have two states, IDLE and RUN; busy=1 exactly in RUN.
REQ-017 IDLE with pending!=0: select one channel, clear its pending bit, set its task_active bit, load the counter with TASK_LEN-1, and go to RUN, all at one clock edge.
REQ-018 RUN: task_active shall be held for exactly TASK_LEN cycles; the counter decrements each cycle.
REQ-019 At counter==0 with pending!=0: grant the next channel at the same edge (no idle gap, busy stays 1).
REQ-020 At counter==0 with pending==0: clear task_active and return to IDLE.
REQ-021 Selection with RR_MODE=0: lowest-index set pending bit.
REQ-022 Selection with RR_MODE=1: first set pending bit searching upward, with wrap, from (last granted index + 1) mod NUM_EV; the pointer resets to 0.
REQ-023 Latency: an edge detected at clock edge k with the scheduler idle shall give task_active high from edge k+1.
REQ-024 An edge on a channel whose pending bit is already 1 shall set overflow[i]; pending stays 1 and one task is queued, not two.
REQ-025 An edge on a channel in the same cycle that channel is granted: the grant clears the old request and the new edge sets pending[i] again; no overflow.
REQ-026 An edge on the channel currently running shall queue a new request normally.
REQ-027 Changing edge_mode to 11 shall not clear an existing pending bit.
REQ-028 ovf_clr=1 shall clear all overflow bits; an overflow event in the same cycle wins, and that bit stays 1.
REQ-029 Simultaneous edges on several channels shall all set their pending bits in the same cycle.

Reset
REQ-030 While rst=1: task_active=0, pending=0, overflow=0, busy=0, FSM=IDLE, counter=0, RR pointer=0.
REQ-031 While rst=1: prev is loaded from event_in, so inputs already high at reset release produce no spurious edge.
REQ-032 Assertion of rst mid-task shall abort the task; all outputs read reset values the cycle after the rst edge.

Verification (NUM_EV=4, TASK_LEN=3, all modes rising unless stated)
REQ-033 event_in[0] 0->1 at edge k, idle -> pending[0]=1 after k; task_active=0001 for edges k+1..k+3; busy=0 after k+4.
REQ-034 event_in[1] and event_in[2] rise in the same cycle, RR_MODE=0 -> task_active sequence 0010 for 3 cycles, then 0100 for 3 cycles, with no gap and busy constant 1.
REQ-035 Channel 3 set to falling: a 1->0 on event_in[3] schedules a task; a 0->1 on event_in[3] does not; mode 11 blocks both edges.
REQ-036 Two rising edges on channel 2 while channel 0 runs -> overflow[2]=1, only one channel-2 task runs; ovf_clr pulse -> overflow=0000.
REQ-037 RR_MODE=1 with channels 0 and 1 re-triggered continuously -> grants alternate 0,1,0,1; fixed mode instead starves channel 1 while channel 0 is re-triggered.
REQ-038 rst pulsed during the second cycle of a task -> next cycle task_active=0000, pending=0000, busy=0; event_in held high through reset -> no task after release.
